// File: rtl/shift_left_seq_if.sv
// Request/response bus for shift_left_seq: start, operands and the result/busy/done handshake.
// The rotate line exists only when SHL_ROTATE_EN is defined.
interface shift_left_seq_if;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
`ifdef SHL_ROTATE_EN
   logic        rotate;
`endif
   logic [31:0] result;
   logic        busy;
   logic        done;

`ifdef SHL_ROTATE_EN
   modport master (output start, A, B, rotate, input result, busy, done);
   modport slave  (input start, A, B, rotate, output result, busy, done);
`else
   modport master (output start, A, B, input result, busy, done);
   modport slave  (input start, A, B, output result, busy, done);
`endif
endinterface

// File: rtl/shift_left_seq.sv
// Sequential 32-bit left shifter, one bit per clock, start/busy/done handshake.
// Define SHL_ROTATE_EN to add the rotate-left mode (bus.rotate).
module shift_left_seq (
   input logic              clk,
   input logic              clr,
   shift_left_seq_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] work_q, work_d;
   logic [31:0] result_q, result_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        rot_q, rot_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        rot_in;
   logic        in_range;
   logic [5:0]  n_eff;
   logic [31:0] load_val;
   logic [31:0] shifted;

   always_comb begin
`ifdef SHL_ROTATE_EN
      rot_in = bus.rotate;
`else
      rot_in = 1'b0;
`endif
      in_range = (bus.B[31:5] == 27'd0);
      // Rotate wraps the amount modulo 32; an out-of-range logical shift clears everything at once.
      if (rot_in || in_range) begin
         n_eff    = {1'b0, bus.B[4:0]};
         load_val = bus.A;
      end else begin
         n_eff    = 6'd0;
         load_val = 32'd0;
      end
      shifted = {work_q[30:0], rot_q & work_q[31]};
   end

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      rot_d    = rot_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         SHIFT: begin
            work_d = shifted;
            cnt_d  = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               result_d = shifted;
               state_d  = DONE;
               done_d   = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: begin
            // IDLE and DONE both accept, which gives back-to-back issue from DONE.
            state_d = IDLE;
            if (bus.start) begin
               work_d = load_val;
               cnt_d  = n_eff;
               rot_d  = rot_in;
               if (n_eff != 6'd0) begin
                  state_d = SHIFT;
                  busy_d  = 1'b1;
               end else begin
                  result_d = load_val;
                  state_d  = DONE;
                  done_d   = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= IDLE;
         work_q   <= 32'd0;
         result_q <= 32'd0;
         cnt_q    <= 6'd0;
         rot_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         rot_q    <= rot_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.result = result_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// Randomized and directed bench for shift_left_seq with a cycle-level behavioural model.
module tb_shift_left_seq;
   logic clk = 1'b0;
   logic clr;

   shift_left_seq_if bus();

   shift_left_seq dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: remaining busy cycles, pending result, visible result, done flag.
   int          m_rem    = 0;
   logic [31:0] m_pend   = 32'd0;
   logic [31:0] m_result = 32'd0;
   logic        m_done   = 1'b0;
   int          m_n;
   logic [31:0] m_r;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic rot);
      int n;
      if (rot) begin
         n = int'(b % 32);
         return (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      end
      return (b >= 32) ? 32'd0 : (a << b);
   endfunction

   function automatic int ref_count(input logic [31:0] b, input logic rot);
      if (rot) return int'(b % 32);
      return (b >= 32) ? 0 : int'(b);
   endfunction

   function automatic logic cur_rot();
`ifdef SHL_ROTATE_EN
      return bus.rotate;
`else
      return 1'b0;
`endif
   endfunction

   task automatic set_rot(input logic rot);
`ifdef SHL_ROTATE_EN
      bus.rotate = rot;
`else
      if (rot) $display("note: rotate requested but SHL_ROTATE_EN undefined");
`endif
   endtask

   // Model update on each edge, then compare just after it.
   always @(posedge clk) begin
      if (!clr) begin
         m_rem    = 0;
         m_done   = 1'b0;
         m_result = 32'd0;
      end else if (m_rem > 0) begin
         m_rem--;
         m_done = (m_rem == 0);
         if (m_done) m_result = m_pend;
      end else begin
         m_done = 1'b0;
         if (bus.start) begin
            m_n = ref_count(bus.B, cur_rot());
            m_r = ref_result(bus.A, bus.B, cur_rot());
            if (m_n == 0) begin
               m_done   = 1'b1;
               m_result = m_r;
            end else begin
               m_rem  = m_n;
               m_pend = m_r;
            end
         end
      end
      #1;
      chk("cyc_result", bus.result, m_result);
      chk("cyc_busy", {31'd0, bus.busy}, (m_rem > 0) ? 32'd1 : 32'd0);
      chk("cyc_done", {31'd0, bus.done}, {31'd0, m_done});
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic rot,
                         input logic [31:0] exp_r, input int exp_lat, input bit noise);
      int cnt;
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      set_rot(rot);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (noise) begin
            bus.start = 1'($urandom % 2);
            bus.A     = $urandom;
            bus.B     = $urandom;
         end else begin
            bus.start = 1'b0;
         end
      end while (!bus.done && cnt < 40);
      bus.start = 1'b0;
      chk(rot ? "rol_latency" : "shl_latency", cnt, exp_lat);
      chk(rot ? "rol_result" : "shl_result", bus.result, exp_r);
   endtask

   initial begin
      int cnt;
      clr       = 1'b0;
      bus.start = 1'b0;
      bus.A     = 32'd0;
      bus.B     = 32'd0;
      set_rot(1'b0);

      // Held in reset with start asserted.
      repeat (4) begin
         @(negedge clk);
         bus.start = 1'b1;
         bus.A     = $urandom;
         bus.B     = $urandom;
         chk("rst_result", bus.result, 32'd0);
         chk("rst_busy", {31'd0, bus.busy}, 32'd0);
         chk("rst_done", {31'd0, bus.done}, 32'd0);
      end
      @(negedge clk);
      bus.start = 1'b0;
      clr       = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("idle_done", {31'd0, bus.done}, 32'd0);

      run_op(32'h8000_0001, 32'd4,          1'b0, 32'h0000_0010, 5,  1'b0);
      run_op(32'h1234_5678, 32'd0,          1'b0, 32'h1234_5678, 1,  1'b0);
      run_op(32'hFFFF_FFFF, 32'd32,         1'b0, 32'h0000_0000, 1,  1'b0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b0, 32'h0000_0000, 1,  1'b0);
      run_op(32'h0000_0001, 32'd31,         1'b0, 32'h8000_0000, 32, 1'b0);
      // Starts pulsed during busy with other operands must be ignored.
      run_op(32'h0000_0003, 32'd7,          1'b0, 32'h0000_0180, 8,  1'b1);

      // Back-to-back: start held through DONE.
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 32'h0000_00FF;
      bus.B     = 32'd3;
      @(negedge clk);
      bus.A = 32'hAAAA_0000;
      bus.B = 32'd2;
      cnt   = 1;
      while (!bus.done && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      chk("b2b_latency1", cnt, 4);
      chk("b2b_result1", bus.result, 32'h0000_07F8);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         bus.start = 1'b0;
      end while (!bus.done && cnt < 40);
      chk("b2b_latency2", cnt, 3);
      chk("b2b_result2", bus.result, 32'hAAA8_0000);

      // Abort mid-shift.
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 32'h0000_000F;
      bus.B     = 32'd10;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      chk("abort_result", bus.result, 32'd0);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      clr = 1'b1;
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) cnt++;
      end
      chk("abort_no_done", cnt, 0);
      run_op(32'h0000_0003, 32'd1, 1'b0, 32'h0000_0006, 2, 1'b0);

`ifdef SHL_ROTATE_EN
      run_op(32'h8000_0001, 32'd1,  1'b1, 32'h0000_0003, 2, 1'b0);
      run_op(32'h8000_0001, 32'd33, 1'b1, 32'h0000_0003, 2, 1'b0);
      run_op(32'h1234_5678, 32'd32, 1'b1, 32'h1234_5678, 1, 1'b0);
      run_op(32'h8000_0000, 32'd31, 1'b1, 32'h4000_0000, 32, 1'b0);
`endif

      // Random traffic, including starts while busy, back-to-back and resets.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         bus.start = (($urandom % 3) == 0);
         bus.A     = $urandom;
         case ($urandom % 4)
            0:       bus.B = $urandom % 8;
            1:       bus.B = $urandom % 32;
            2:       bus.B = 32 + ($urandom % 40);
            default: bus.B = $urandom;
         endcase
         set_rot(1'($urandom % 2) & cur_rot_allowed());
         clr = (($urandom % 150) != 0);
      end
      @(negedge clk);
      bus.start = 1'b0;
      clr       = 1'b1;
      repeat (40) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   function automatic logic cur_rot_allowed();
`ifdef SHL_ROTATE_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

endmodule
